// File: rtl/decim_pkg.sv
// Shared types and helpers for the multi-channel decimator.
package decim_pkg;

  typedef enum logic [1:0] {
    MODE_LATEST = 2'd0,
    MODE_MEAN   = 2'd1,
    MODE_PEAK   = 2'd2,
    MODE_RSVD   = 2'd3
  } decim_mode_t;

  // The reserved encoding reduces exactly like LATEST.
  function automatic decim_mode_t decim_eff_mode(input decim_mode_t m);
    return (m == MODE_RSVD) ? MODE_LATEST : m;
  endfunction

endpackage

// File: rtl/multi_channel_decimator_if.sv
// Sample-in / reduced-result-out bundle of the multi-channel decimator.
interface multi_channel_decimator_if #(
  parameter int unsigned S = 12,
  parameter int unsigned C = 4
);
  logic           in_valid;
  logic [C*S-1:0] in_data;
  logic [1:0]     mode;
  logic           out_ready;
  logic           out_valid;
  logic [C*S-1:0] out_data;
  logic           overrun;
  logic           overrun_clr;

  modport master (
    output in_valid, in_data, mode, out_ready, overrun_clr,
    input  out_valid, out_data, overrun
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready, overrun_clr,
    output out_valid, out_data, overrun
  );
endinterface

// File: rtl/decim_channel.sv
// One channel's period accumulator, running peak and LATEST hold; the result
// includes the current cycle's sample so the terminal sample is counted.
module decim_channel
  import decim_pkg::*;
#(
  parameter int unsigned S = 12,
  parameter int unsigned P = 3
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [S-1:0] sample,
  input  logic        valid,
  input  logic        terminal,
  input  decim_mode_t mode,
  output logic [S-1:0] result_c
);

  localparam int unsigned ACC_W = S + P;

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum_c;
  logic [S-1:0]     peak_q, peak_d, peak_cur_c;
  logic [S-1:0]     latest_q, latest_d, latest_cur_c;

  always_comb begin
    acc_sum_c    = acc_q + (valid ? ACC_W'(sample) : '0);
    peak_cur_c   = (valid && (sample > peak_q)) ? sample : peak_q;
    latest_cur_c = valid ? sample : latest_q;

    // Sum and peak restart each period; the LATEST hold carries across.
    acc_d    = terminal ? '0 : acc_sum_c;
    peak_d   = terminal ? '0 : peak_cur_c;
    latest_d = latest_cur_c;

    result_c = latest_cur_c;
    case (decim_eff_mode(mode))
      MODE_MEAN: result_c = S'(acc_sum_c >> P);
      MODE_PEAK: result_c = peak_cur_c;
      default:   result_c = latest_cur_c;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      acc_q    <= '0;
      peak_q   <= '0;
      latest_q <= '0;
    end else begin
      acc_q    <= acc_d;
      peak_q   <= peak_d;
      latest_q <= latest_d;
    end
  end

endmodule

// File: rtl/multi_channel_decimator.sv
// Multi-channel decimator: one reduced word per channel every 2^P cycles,
// presented on a valid/ready output with a sticky overrun flag.
module multi_channel_decimator
  import decim_pkg::*;
#(
  parameter int unsigned S = 12,
  parameter int unsigned C = 4,
  parameter int unsigned P = 3
) (
  input logic                      CLK,
  input logic                      CLR,
  multi_channel_decimator_if.slave bus
);

  logic [P-1:0]   phase_q, phase_d;
  logic           terminal_c;
  decim_mode_t    mode_q, mode_d;
  logic           out_valid_q, out_valid_d;
  logic [C*S-1:0] out_data_q, out_data_d;
  logic           overrun_q, overrun_d;
  logic [C*S-1:0] result_c;

  assign terminal_c = (phase_q == '1);

  for (genvar i = 0; i < C; i++) begin : g_ch
    decim_channel #(.S(S), .P(P)) u_ch (
      .CLK      (CLK),
      .CLR      (CLR),
      .sample   (bus.in_data[i*S +: S]),
      .valid    (bus.in_valid),
      .terminal (terminal_c),
      .mode     (mode_q),
      .result_c (result_c[i*S +: S])
    );
  end

  // Terminal edge loads results and next-period mode; set of overrun beats clear.
  always_comb begin
    phase_d     = phase_q + P'(1);
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    if (bus.overrun_clr) overrun_d = 1'b0;

    if (terminal_c) begin
      mode_d      = decim_mode_t'(bus.mode);
      out_data_d  = result_c;
      out_valid_d = 1'b1;
      if (out_valid_q && !bus.out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      phase_q     <= '0;
      mode_q      <= MODE_LATEST;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overrun   = overrun_q;

endmodule
